// File: rtl/lm_pkg.sv
// ----------------------------------------------------------------------------
// lm_pkg
// Shared types for the LED display multiplexer:
//   lm_mode_e  - display select on the 'mode' input (ERR, DATA, STICKY, STATUS)
//   lm_state_e - state of the data hold FSM in lm_hold_buffer
//   cnt_width  - width of a down-counter that must hold values 0..n-1
// ----------------------------------------------------------------------------
package lm_pkg;

    typedef enum logic [1:0] {
        LM_ERR    = 2'd0,
        LM_DATA   = 2'd1,
        LM_STICKY = 2'd2,
        LM_STATUS = 2'd3
    } lm_mode_e;

    typedef enum logic {
        LM_IDLE = 1'b0,
        LM_HOLD = 1'b1
    } lm_state_e;

    // A counter holding n-1 needs at least one bit, even when n is 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lm_hold_buffer.sv
// ----------------------------------------------------------------------------
// lm_hold_buffer
// Keeps each received byte on display for at least HOLD_CYC cycles. While a
// byte is being held, one further byte may wait in a single pending slot; a
// newer byte overwrites it and raises the overflow flag until clear_i.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   valid_i    - one-cycle strobe for data_i
//   data_i     - received byte
//   clear_i    - clears the overflow flag
//   disp_d_o   - displayed byte as it will be after this edge (next-state),
//                so the parent can register it without an extra cycle
//   overflow_o - registered overflow flag
// ----------------------------------------------------------------------------
module lm_hold_buffer
    import lm_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int HOLD_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              clear_i,
    output logic [DATA_W-1:0] disp_d_o,
    output logic              overflow_o
);

    localparam int              CNT_W      = cnt_width(HOLD_CYC);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYC - 1);

    lm_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] disp_q, disp_d;
    logic [DATA_W-1:0] pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic              ovf_q, ovf_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned; a missing default here infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        disp_d     = disp_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        ovf_d      = ovf_q & ~clear_i;

        unique case (state_q)
            LM_IDLE: begin
                if (valid_i) begin
                    disp_d  = data_i;
                    cnt_d   = CNT_RELOAD;
                    state_d = LM_HOLD;
                end
            end
            LM_HOLD: begin
                if (cnt_q == '0) begin
                    if (pend_vld_q) begin
                        // Promote the waiting byte; a byte arriving now takes
                        // the slot it just vacated, so this is not an overflow.
                        disp_d     = pend_q;
                        cnt_d      = CNT_RELOAD;
                        pend_vld_d = valid_i;
                        if (valid_i) pend_d = data_i;
                    end else if (valid_i) begin
                        disp_d = data_i;
                        cnt_d  = CNT_RELOAD;
                    end else begin
                        state_d = LM_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (valid_i) begin
                        pend_d     = data_i;
                        pend_vld_d = 1'b1;
                        // A fresh overwrite wins over a simultaneous clear.
                        if (pend_vld_q) ovf_d = 1'b1;
                    end
                end
            end
            default: state_d = LM_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the displayed and pending bytes are storage but are reset
            // anyway, so a reset mid-hold can never resurface a stale byte.
            state_q    <= LM_IDLE;
            cnt_q      <= '0;
            disp_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            disp_q     <= disp_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            ovf_q      <= ovf_d;
        end
    end

    assign disp_d_o   = disp_d;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/led_display_mux.sv
// ----------------------------------------------------------------------------
// led_display_mux
// Drives a bank of LEDs with one of four views selected by 'mode':
//   ERR    - last CM / UART error vectors plus heartbeat on the top LED
//   DATA   - received UART bytes, each held for at least HOLD_CYC cycles
//   STICKY - OR-accumulated CM / UART errors (cleared by err_clear) + heartbeat
//   STATUS - config_notification
// leds is registered and reflects an input change one cycle later.
//
// Build option: define LM_HEARTBEAT_EN to drive leds[LED_W-1] from a
// free-running divider (toggles every 2^BLINK_DIV cycles); otherwise it is 0
// and no divider exists.
//
// Ports:
//   clk, rst                              - clock, synchronous active-high reset
//   mode                                  - display select
//   UART_data, UART_data_valid            - received byte and strobe
//   CM_errors, CM_errors_valid            - CM error vector and strobe
//   UART_errors, UART_errors_valid        - UART error vector and strobe
//   err_clear                             - clears sticky errors and overflow
//   config_notification                   - configuration status byte
//   leds                                  - registered LED drive
//   data_overflow                         - a pending byte was overwritten
// ----------------------------------------------------------------------------
module led_display_mux
    import lm_pkg::*;
#(
    parameter int LED_W      = 8,
    parameter int DATA_W     = 8,
    parameter int CM_ERR_W   = 4,
    parameter int UART_ERR_W = 2,
    parameter int HOLD_CYC   = 1024,
    parameter int BLINK_DIV  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic [DATA_W-1:0]     UART_data,
    input  logic                  UART_data_valid,
    input  logic [CM_ERR_W-1:0]   CM_errors,
    input  logic                  CM_errors_valid,
    input  logic [UART_ERR_W-1:0] UART_errors,
    input  logic                  UART_errors_valid,
    input  logic                  err_clear,
    input  logic [7:0]            config_notification,
    output logic [LED_W-1:0]      leds,
    output logic                  data_overflow
);

    // The error views need both vectors below the heartbeat LED.
    if (CM_ERR_W + UART_ERR_W > LED_W - 1) begin : g_width_check
        $error("led_display_mux: CM_ERR_W + UART_ERR_W exceeds LED_W - 1");
    end

    lm_mode_e mode_e;
    assign mode_e = lm_mode_e'(mode);

    // Data path
    logic [DATA_W-1:0] disp_d;

    lm_hold_buffer #(
        .DATA_W   (DATA_W),
        .HOLD_CYC (HOLD_CYC)
    ) u_hold (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (UART_data_valid),
        .data_i     (UART_data),
        .clear_i    (err_clear),
        .disp_d_o   (disp_d),
        .overflow_o (data_overflow)
    );

    // Error registers
    logic [CM_ERR_W-1:0]   cm_last_q, cm_last_d, cm_sticky_q, cm_sticky_d;
    logic [UART_ERR_W-1:0] ua_last_q, ua_last_d, ua_sticky_q, ua_sticky_d;

    assign cm_last_d   = CM_errors_valid ? CM_errors : cm_last_q;
    assign ua_last_d   = UART_errors_valid ? UART_errors : ua_last_q;
    // Clear and a new vector together leave exactly the new vector.
    assign cm_sticky_d = (err_clear ? '0 : cm_sticky_q) | (CM_errors_valid ? CM_errors : '0);
    assign ua_sticky_d = (err_clear ? '0 : ua_sticky_q) | (UART_errors_valid ? UART_errors : '0);

    // Heartbeat
    logic hb_d;
`ifdef LM_HEARTBEAT_EN
    logic [BLINK_DIV:0] hb_cnt_q, hb_cnt_d;
    assign hb_cnt_d = hb_cnt_q + 1'b1;
    assign hb_d     = hb_cnt_d[BLINK_DIV];

    always_ff @(posedge clk) begin
        if (rst) hb_cnt_q <= '0;
        else     hb_cnt_q <= hb_cnt_d;
    end
`else
    assign hb_d = 1'b0;
`endif

    // Truncate or zero-extend the byte views to the LED width.
    logic [LED_W-1:0] data_rs, stat_rs;
    for (genvar g = 0; g < LED_W; g++) begin : g_resize
        if (g < DATA_W) begin : g_data
            assign data_rs[g] = disp_d[g];
        end else begin : g_data_pad
            assign data_rs[g] = 1'b0;
        end
        if (g < 8) begin : g_stat
            assign stat_rs[g] = config_notification[g];
        end else begin : g_stat_pad
            assign stat_rs[g] = 1'b0;
        end
    end

    // Output select works on next-state values so leds lags inputs by one cycle.
    logic [LED_W-1:0] leds_q, leds_d;

    always_comb begin
        leds_d = '0;
        unique case (mode_e)
            LM_ERR: begin
                leds_d[CM_ERR_W-1:0]          = cm_last_d;
                leds_d[CM_ERR_W +: UART_ERR_W] = ua_last_d;
                leds_d[LED_W-1]               = hb_d;
            end
            LM_STICKY: begin
                leds_d[CM_ERR_W-1:0]          = cm_sticky_d;
                leds_d[CM_ERR_W +: UART_ERR_W] = ua_sticky_d;
                leds_d[LED_W-1]               = hb_d;
            end
            LM_DATA:   leds_d = data_rs;
            LM_STATUS: leds_d = stat_rs;
            default:   leds_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            leds_q      <= '0;
            cm_last_q   <= '0;
            ua_last_q   <= '0;
            cm_sticky_q <= '0;
            ua_sticky_q <= '0;
        end else begin
            leds_q      <= leds_d;
            cm_last_q   <= cm_last_d;
            ua_last_q   <= ua_last_d;
            cm_sticky_q <= cm_sticky_d;
            ua_sticky_q <= ua_sticky_d;
        end
    end

    assign leds = leds_q;

endmodule

// File: tb/tb_led_display_mux.sv
// ----------------------------------------------------------------------------
// tb_led_display_mux
// Directed scenarios with literal expectations, then randomized traffic. A
// timestamp/queue model of the display rules is checked against leds and
// data_overflow after every clock edge. Define LM_HEARTBEAT_EN for both the
// RTL and this bench to exercise the heartbeat build.
// ----------------------------------------------------------------------------
module tb_led_display_mux;

    localparam int LED_W = 8, DATA_W = 8, CM_W = 4, UA_W = 2;
    localparam int HOLD = 4, BDIV = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      mode = 2'd0;
    logic [7:0]      uart_data = 8'h00;
    logic            uart_dv = 1'b0;
    logic [CM_W-1:0] cm_err = '0;
    logic            cm_v = 1'b0;
    logic [UA_W-1:0] ua_err = '0;
    logic            ua_v = 1'b0;
    logic            err_clear = 1'b0;
    logic [7:0]      cfg = 8'h00;
    logic [7:0]      leds;
    logic            ovf;

    int n_checks = 0;
    int n_err    = 0;

    led_display_mux #(
        .LED_W(LED_W), .DATA_W(DATA_W), .CM_ERR_W(CM_W), .UART_ERR_W(UA_W),
        .HOLD_CYC(HOLD), .BLINK_DIV(BDIV)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .UART_data(uart_data), .UART_data_valid(uart_dv),
        .CM_errors(cm_err), .CM_errors_valid(cm_v),
        .UART_errors(ua_err), .UART_errors_valid(ua_v),
        .err_clear(err_clear), .config_notification(cfg),
        .leds(leds), .data_overflow(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A byte loaded at edge L owns the display until edge L+HOLD; at that edge
    // a waiting byte (or one arriving right then) takes over.
    logic [7:0]      m_disp;
    logic [7:0]      m_pend[$];
    bit              m_active;
    int              m_edge, m_load_t, m_hb;
    bit              m_ovf;
    logic [CM_W-1:0] m_cm, m_scm;
    logic [UA_W-1:0] m_ua, m_sua;
    logic [7:0]      m_leds;

    always @(posedge clk) begin
        bit hb_bit, ovf_set;
        if (rst) begin
            m_disp = 8'h00; m_pend.delete(); m_active = 0; m_edge = 0; m_load_t = 0;
            m_hb = 0; m_ovf = 0; m_cm = '0; m_scm = '0; m_ua = '0; m_sua = '0;
            m_leds = 8'h00;
        end else begin
            m_edge++;
            m_hb++;
            if (cm_v) m_cm = cm_err;
            if (ua_v) m_ua = ua_err;
            m_scm = (err_clear ? '0 : m_scm) | (cm_v ? cm_err : '0);
            m_sua = (err_clear ? '0 : m_sua) | (ua_v ? ua_err : '0);

            ovf_set = 0;
            if (m_active && (m_edge - m_load_t) < HOLD) begin
                if (uart_dv) begin
                    if (m_pend.size() != 0) begin ovf_set = 1; m_pend[0] = uart_data; end
                    else m_pend.push_back(uart_data);
                end
            end else if (m_pend.size() != 0) begin
                m_disp = m_pend.pop_front(); m_load_t = m_edge; m_active = 1;
                if (uart_dv) m_pend.push_back(uart_data);
            end else if (uart_dv) begin
                m_disp = uart_data; m_load_t = m_edge; m_active = 1;
            end else begin
                m_active = 0;
            end
            m_ovf = (m_ovf && !err_clear) || ovf_set;

`ifdef LM_HEARTBEAT_EN
            hb_bit = ((m_hb >> BDIV) & 1) != 0;
`else
            hb_bit = 0;
`endif
            case (mode)
                2'd0:    m_leds = {hb_bit, 1'b0, m_ua, m_cm};
                2'd1:    m_leds = m_disp;
                2'd2:    m_leds = {hb_bit, 1'b0, m_sua, m_scm};
                default: m_leds = cfg;
            endcase
        end
        #1;
        check("model leds", leds, m_leds);
        check("model overflow", ovf, m_ovf);
    end

    // ---------------- stimulus ----------------
    task automatic strobes_off();
        uart_dv = 0; cm_v = 0; ua_v = 0; err_clear = 0;
    endtask

    task automatic after_edge();
        @(posedge clk); #2;
    endtask

    initial begin
        logic [7:0] seq_in  [0:9];
        logic [7:0] seq_exp [0:9];
        logic       hb_s    [0:23];

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("reset leds", leds, 8'h00);
        check("reset overflow", ovf, 1'b0);

        // ERR view: last CM and UART vectors
        @(negedge clk); rst = 0; mode = 2'd0; cm_err = 4'hA; cm_v = 1; ua_err = 2'b01; ua_v = 1;
        after_edge();
        check("err view low bits", leds[5:0], 6'h1A);

        // STICKY view: accumulate, then clear with a coincident vector
        @(negedge clk); strobes_off(); mode = 2'd2; err_clear = 1;
        after_edge();
        check("sticky after clear", leds[5:0], 6'h00);
        @(negedge clk); strobes_off(); cm_err = 4'h1; cm_v = 1;
        after_edge();
        @(negedge clk); cm_err = 4'h4; cm_v = 1;
        after_edge();
        check("sticky or", leds[3:0], 4'h5);
        @(negedge clk); cm_err = 4'h2; cm_v = 1; err_clear = 1;
        after_edge();
        check("sticky clear+valid", leds[3:0], 4'h2);

        // DATA view: three back-to-back bytes, middle one overwritten
        seq_in  = '{8'h11, 8'h22, 8'h33, 0, 0, 0, 0, 0, 0, 0};
        seq_exp = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); strobes_off(); mode = 2'd1;
            uart_dv = (i < 3); uart_data = seq_in[i];
            after_edge();
            check($sformatf("hold seq %0d", i), leds, seq_exp[i]);
            if (i == 2) check("overflow set", ovf, 1'b1);
        end
        check("overflow sticky", ovf, 1'b1);
        @(negedge clk); err_clear = 1;
        after_edge();
        check("overflow cleared", ovf, 1'b0);

        // Reset during HOLD with a pending byte
        seq_in = '{8'h55, 8'h66, 8'h77, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); strobes_off(); uart_dv = 1; uart_data = seq_in[i];
            after_edge();
        end
        check("overflow before reset", ovf, 1'b1);
        @(negedge clk); strobes_off(); rst = 1;
        after_edge();
        check("reset mid-hold leds", leds, 8'h00);
        check("reset mid-hold overflow", ovf, 1'b0);
        @(negedge clk); rst = 0;
        for (int i = 0; i < 8; i++) begin
            after_edge();
            check($sformatf("no pending after reset %0d", i), leds, 8'h00);
        end

        // STATUS view, then switch to DATA mid-hold
        @(negedge clk); mode = 2'd3; cfg = 8'hC3;
        after_edge();
        check("status view", leds, 8'hC3);
        @(negedge clk); uart_dv = 1; uart_data = 8'h77;
        after_edge();
        check("status while loading", leds, 8'hC3);
        @(negedge clk); mode = 2'd1; uart_data = 8'h88;
        after_edge();
        check("data after switch L+1", leds, 8'h77);
        @(negedge clk); strobes_off();
        after_edge();
        check("data after switch L+2", leds, 8'h77);
        after_edge();
        check("data after switch L+3", leds, 8'h77);
        after_edge();
        check("pending shown at L+4", leds, 8'h88);

        // Heartbeat bit
        @(negedge clk); mode = 2'd0;
        for (int i = 0; i < 24; i++) begin
            after_edge();
            hb_s[i] = leds[7];
        end
`ifdef LM_HEARTBEAT_EN
        for (int i = 8; i < 24; i++) check($sformatf("heartbeat toggle %0d", i), hb_s[i] ^ hb_s[i-8], 1'b1);
`else
        for (int i = 0; i < 24; i++) check($sformatf("heartbeat off %0d", i), hb_s[i], 1'b0);
`endif

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            uart_dv   = ($urandom_range(0, 2) == 0);
            uart_data = 8'($urandom);
            cm_v      = ($urandom_range(0, 3) == 0);
            cm_err    = CM_W'($urandom);
            ua_v      = ($urandom_range(0, 3) == 0);
            ua_err    = UA_W'($urandom);
            err_clear = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 31) == 0) cfg = 8'($urandom);
        end
        @(negedge clk); rst = 0; strobes_off();
        repeat (2) @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
